// File: rtl/aes_uart_top.sv
// AES-128 encryption appliance on a UART link.
// Expands a fixed key after reset, assembles 16 plaintext bytes from rx (8N1),
// encrypts iteratively (one round per cycle) and streams the 16 ciphertext
// bytes back on tx, MSB byte first.
module aes_uart_top #(
    parameter int unsigned  CLKS_PER_BIT = 864,
    parameter logic [127:0] AES_KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx
);

    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] f_xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One cipher round; the final round skips MixColumns.
    function automatic logic [127:0] f_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
        logic [7:0]   b [16];
        logic [7:0]   h [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = f_sbox(s[127-8*i -: 8]);
        // Byte 4c+r is row r of column c; row r rotates left by r columns.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) h[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = h[4*c]; a1 = h[4*c+1]; a2 = h[4*c+2]; a3 = h[4*c+3];
            if (last)
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                o[127-32*c -: 32] = {
                    f_xt(a0) ^ f_xt(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ f_xt(a1) ^ f_xt(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ f_xt(a2) ^ f_xt(a3) ^ a3,
                    f_xt(a0) ^ a0 ^ a1 ^ a2 ^ f_xt(a3)};
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] f_next_key(input logic [127:0] p, input logic [7:0] rcon);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {f_sbox(p[23:16]) ^ rcon, f_sbox(p[15:8]), f_sbox(p[7:0]), f_sbox(p[31:24])};
        n0 = p[127:96] ^ t;
        n1 = p[95:64]  ^ n0;
        n2 = p[63:32]  ^ n1;
        n3 = p[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // ---------------------------------------------------------------- key schedule
    logic           keys_generated;
    logic [3:0]     r_kx_idx;
    logic [7:0]     r_rcon;
    logic [127:0]   r_kx_prev;
    logic [127:0]   r_rk [0:10];
    logic [127:0]   w_kx_key;

    assign w_kx_key = (r_kx_idx == 4'd0) ? AES_KEY : f_next_key(r_kx_prev, r_rcon);

    // Key-expansion sequencer: one round key per cycle, then hold until reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every clocked block uses <= so all registers update from pre-edge values.
        if (!reset) begin
            keys_generated <= 1'b0;
            r_kx_idx       <= '0;
            r_rcon         <= 8'h01;
            r_kx_prev      <= '0;
        end else if (!keys_generated) begin
            r_kx_prev <= w_kx_key;
            if (r_kx_idx != 4'd0) r_rcon <= f_xt(r_rcon);
            if (r_kx_idx == 4'd10) keys_generated <= 1'b1;
            else                   r_kx_idx       <= r_kx_idx + 4'd1;
        end
    end

    // Round-key register file write port.
    always_ff @(posedge clk) begin
        // NOTE: the round-key file has no reset; it is fully rewritten before
        // keys_generated rises and nothing reads it before then.
        if (!keys_generated) r_rk[r_kx_idx] <= w_kx_key;
    end

    // ---------------------------------------------------------------- UART RX
    uart_state_t    r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]     r_rx_bit, w_rx_bit_nxt;
    logic [7:0]     r_rx_shift, w_rx_shift_nxt;
    logic           r_rx_ferr, w_rx_ferr_nxt;
    logic           r_rx_meta, r_rx_sync;
    logic           w_rx_valid;

    // Two-flop synchronizer for the asynchronous rx line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_ferr  <= w_rx_ferr_nxt;
        end
    end

    // RX next state: resync on every start edge; a framing error waits for the line to go high.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_ferr_nxt  = r_rx_ferr;
        w_rx_valid     = 1'b0;
        unique case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt  = '0;
                w_rx_ferr_nxt = 1'b0;
                if (!r_rx_sync) w_rx_state_nxt = S_START;
            end
            S_START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_rx_ferr) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_sync) w_rx_state_nxt = S_IDLE;
                end else if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nxt = '0;
                    if (r_rx_sync) begin
                        w_rx_valid     = 1'b1;
                        w_rx_state_nxt = S_IDLE;
                    end else begin
                        w_rx_ferr_nxt = 1'b1;
                    end
                end
            end
            default: w_rx_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- block assembly
    logic [3:0]     r_byte_cnt;
    logic [119:0]   r_asm;
    logic           r_pending;
    logic [127:0]   r_pend_pt;
    logic           r_blk_busy;
    logic           w_start;
    logic           w_tx_done;

    assign w_start = r_pending && !r_blk_busy;

    // Collect bytes MSB first; a full block parks in the single pending slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_pending  <= 1'b0;
            r_pend_pt  <= '0;
            r_blk_busy <= 1'b0;
        end else begin
            if (w_rx_valid && keys_generated) begin
                r_asm      <= {r_asm[111:0], r_rx_shift};
                r_byte_cnt <= r_byte_cnt + 4'd1;
                if (r_byte_cnt == 4'd15 && !r_pending) begin
                    r_pending <= 1'b1;
                    r_pend_pt <= {r_asm, r_rx_shift};
                end
            end
            if (w_start) begin
                r_pending  <= 1'b0;
                r_blk_busy <= 1'b1;
            end else if (w_tx_done) begin
                r_blk_busy <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- cipher
    logic [127:0]   r_state;
    logic [3:0]     r_round;
    logic           r_cbusy;
    logic           result_valid;
    logic [127:0]   ct;
    logic [127:0]   w_round_out;

    assign w_round_out = f_round(r_state, r_rk[r_round], r_round == 4'd10);

    // Iterative cipher: initial AddRoundKey on start, then rounds 1..10 one per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= '0;
            r_round      <= '0;
            r_cbusy      <= 1'b0;
            result_valid <= 1'b0;
            ct           <= '0;
        end else begin
            result_valid <= 1'b0;
            if (w_start) begin
                r_state <= r_pend_pt ^ r_rk[0];
                r_round <= 4'd1;
                r_cbusy <= 1'b1;
            end else if (r_cbusy) begin
                if (r_round == 4'd10) begin
                    ct           <= w_round_out;
                    result_valid <= 1'b1;
                    r_cbusy      <= 1'b0;
                end else begin
                    r_state <= w_round_out;
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- UART TX
    uart_state_t    r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]     r_tx_bit, w_tx_bit_nxt;
    logic [3:0]     r_tx_idx, w_tx_idx_nxt;
    logic [127:0]   r_tx_data, w_tx_data_nxt;

    // TX state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_data  <= w_tx_data_nxt;
        end
    end

    // TX next state: 16 back-to-back frames, MSB byte first.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_done      = 1'b0;
        unique case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (result_valid) begin
                    w_tx_data_nxt  = ct;
                    w_tx_idx_nxt   = '0;
                    w_tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    w_tx_bit_nxt = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nxt  = '0;
                    w_tx_data_nxt = {r_tx_data[119:0], 8'h00};
                    if (r_tx_idx == 4'd15) begin
                        w_tx_done      = 1'b1;
                        w_tx_state_nxt = S_IDLE;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 4'd1;
                        w_tx_state_nxt = S_START;
                    end
                end
            end
            default: w_tx_state_nxt = S_IDLE;
        endcase
    end

    // Line driver: high when idle or in the stop bit, so reset forces it high at once.
    always_comb begin
        unique case (r_tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = r_tx_data[120 + 32'(r_tx_bit)];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_aes_uart_top.sv
// Directed bench for aes_uart_top: FIPS-197 / SP800-38A vectors over a
// scaled-down UART (64 clk/bit in the DUT, 65 clk/bit from the sender).
module tb_aes_uart_top;

    localparam int CPB    = 64;
    localparam int BIT_TX = 65;

    localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic clk = 1'b0;
    logic reset;
    logic rx;
    logic tx;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int           rv_count     = 0;
    int           rv_run       = 0;
    int           rv_max_width = 0;
    logic [127:0] rv_ct        = '0;

    logic [7:0] q_byte [$];
    logic       q_stop [$];
    int         q_t0   [$];

    aes_uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count result_valid pulses, capture ct, track the longest pulse.
    always @(negedge clk) begin
        if (dut.result_valid === 1'b1) begin
            rv_run = rv_run + 1;
            if (rv_run == 1) begin
                rv_count = rv_count + 1;
                rv_ct    = dut.ct;
            end
            if (rv_run > rv_max_width) rv_max_width = rv_run;
        end else begin
            rv_run = 0;
        end
    end

    // Decode tx frames at the DUT bit rate.
    initial begin : tx_decoder
        logic [7:0] b;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) @(negedge clk);
                        b[k] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                    q_stop.push_back(tx);
                    q_byte.push_back(b);
                    q_t0.push_back(t0);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_TX) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (BIT_TX) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_TX) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_TX) @(negedge clk);
    endtask

    task automatic send_block(input logic [127:0] pt, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(pt[127-8*i -: 8], 1'b1);
    endtask

    task automatic wait_keys();
        for (int i = 0; i < 12 && dut.keys_generated !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_result(input int target);
        for (int i = 0; i < 3000 && rv_count < target; i++) @(negedge clk);
    endtask

    task automatic wait_tx_bytes(input int target);
        for (int i = 0; i < 15000 && q_byte.size() < target; i++) @(negedge clk);
    endtask

    // Gather 16 decoded bytes starting at index base into one block.
    function automatic logic [127:0] tx_block(input int base);
        logic [127:0] v = '0;
        for (int i = 0; i < 16; i++)
            if (base + i < q_byte.size()) v[127-8*i -: 8] = q_byte[base+i];
        return v;
    endfunction

    initial begin
        int bad_stop;
        int bad_gap;

        // Test 1: reset state and key expansion.
        rx    = 1'b1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_keys_generated", dut.keys_generated, 1'b0);
        check("rst_result_valid", dut.result_valid, 1'b0);
        check("rst_ct", dut.ct, '0);
        reset = 1'b1;
        wait_keys();
        check("keys_generated_12clk", dut.keys_generated, 1'b1);
        check("idle_tx", tx, 1'b1);
        check("idle_no_result", rv_count, 0);

        // Test 2: first vector, 65 clk/bit, one idle bit between bytes.
        send_block(PT1, 0, 15);
        wait_result(1);
        check("t2_result_count", rv_count, 1);
        check("t2_ct", rv_ct, CT1);
        check("t2_valid_width", rv_max_width, 1);

        // Test 4: second vector while the first ciphertext drains on tx.
        send_block(PT2, 0, 15);
        wait_result(2);
        check("t4_result_count", rv_count, 2);
        check("t4_ct", rv_ct, CT2);

        // Test 3: tx stream of the first ciphertext.
        check("t3_nbytes", q_byte.size() >= 16, 1'b1);
        check("t3_tx_bytes", tx_block(0), CT1);
        bad_stop = 0;
        bad_gap  = 0;
        for (int i = 0; i < 16 && i < q_byte.size(); i++) begin
            if (q_stop[i] !== 1'b1) bad_stop++;
            if (i > 0 && q_t0[i] - q_t0[i-1] != 10 * CPB) bad_gap++;
        end
        check("t3_stop_bits", bad_stop, 0);
        check("t3_frame_spacing", bad_gap, 0);
        wait_tx_bytes(32);
        repeat (CPB) @(negedge clk);
        check("t4_tx_bytes", tx_block(16), CT2);
        check("t3_tx_idle_high", tx, 1'b1);

        // Test 5: framing-error byte in the middle of a block is dropped.
        send_block(PT1, 0, 4);
        send_byte(8'h5a, 1'b0);
        send_block(PT1, 5, 15);
        wait_result(3);
        check("t5_result_count", rv_count, 3);
        check("t5_ct", rv_ct, CT1);

        // Test 6: reset after 7 bytes (tx still sending), then a clean block.
        send_block(PT2, 0, 6);
        reset = 1'b0;
        #1;
        check("t6_tx_high_in_reset", tx, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_keys_cleared", dut.keys_generated, 1'b0);
        check("t6_ct_cleared", dut.ct, '0);
        reset = 1'b1;
        wait_keys();
        check("t6_keys_generated", dut.keys_generated, 1'b1);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("t6_no_result_yet", rv_count, 3);
        send_block(PT2, 0, 15);
        wait_result(4);
        check("t6_result_count", rv_count, 4);
        check("t6_ct", rv_ct, CT2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
